// File: rtl/phase_reset_if.sv
// phase_reset_if: button/phase-hold inputs, strobes, reset and step-count outputs of phase_reset_ctrl
interface phase_reset_if;
  logic        btn_in;
  logic        phase_hold;
  logic        ce_core;
  logic        ce_imem;
  logic        ce_dmem;
  logic [2:0]  phase;
  logic        btn_pressed;
  logic        rst_mem;
  logic        rst_core;
  logic [31:0] step_cnt;
  modport master (
    output btn_in, phase_hold,
    input  ce_core, ce_imem, ce_dmem, phase, btn_pressed, rst_mem, rst_core, step_cnt
  );
  modport slave (
    input  btn_in, phase_hold,
    output ce_core, ce_imem, ce_dmem, phase, btn_pressed, rst_mem, rst_core, step_cnt
  );
endinterface

// File: rtl/phase_reset_ctrl.sv
// phase_reset_ctrl: single-clock phase strobes, debounced button, staged mem/core reset, step counter
module phase_reset_ctrl #(
  parameter int NPHASE       = 3,
  parameter int IMEM_PHASE   = 1,
  parameter int DMEM_PHASE   = 2,
  parameter int DEBOUNCE_LEN = 16,
  parameter int RST_HOLD     = 4,
  parameter int BTN_ACT_LOW  = 1
) (
  input logic         clk,
  input logic         rst,
  phase_reset_if.slave bus
);
  localparam int PW = NPHASE > 1 ? $clog2(NPHASE) : 1;
  typedef enum logic [1:0] {RESET, MEM_UP, RUN} state_t;
  state_t                  state;
  logic [PW-1:0]           ph;
  logic                    raw_p, s1, s2, pressed, rst_mem_q, rst_core_q, run_en;
  logic [DEBOUNCE_LEN-2:0] sh;
  logic [DEBOUNCE_LEN-1:0] sh_n;
  logic [7:0]              hold_cnt;
  logic [31:0]             step_q;
  if (NPHASE < 1 || NPHASE > 8 || IMEM_PHASE >= NPHASE || DMEM_PHASE >= NPHASE) begin : g_bad_param
    $error("phase_reset_ctrl: NPHASE must be 1..8 and IMEM_PHASE/DMEM_PHASE below NPHASE");
  end
  assign raw_p = BTN_ACT_LOW != 0 ? ~bus.btn_in : bus.btn_in;
  // Debounce window spans DEBOUNCE_LEN samples: the stored history plus the newest synchronised bit.
  assign sh_n = {sh, s2};
  assign run_en = ~rst & ~bus.phase_hold;
  assign bus.ce_core = run_en & (ph == '0);
  assign bus.ce_imem = run_en & (ph == PW'(IMEM_PHASE));
  assign bus.ce_dmem = run_en & (ph == PW'(DMEM_PHASE));
  assign bus.phase = 3'(ph);
  assign bus.btn_pressed = pressed;
  assign bus.rst_mem = rst_mem_q;
  assign bus.rst_core = rst_core_q;
  assign bus.step_cnt = step_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ph         <= '0;
      s1         <= 1'b1;
      s2         <= 1'b1;
      sh         <= '1;
      pressed    <= 1'b1;
      state      <= RESET;
      hold_cnt   <= '0;
      rst_mem_q  <= 1'b1;
      rst_core_q <= 1'b1;
      step_q     <= '0;
    end else begin
      if (!bus.phase_hold) ph <= (ph == PW'(NPHASE - 1)) ? '0 : ph + PW'(1);
      s1      <= raw_p;
      s2      <= s1;
      sh      <= sh_n[DEBOUNCE_LEN-2:0];
      pressed <= (&sh_n) | (pressed & (|sh_n));
      rst_mem_q  <= state == RESET;
      rst_core_q <= state != RUN;
      if (state == RUN && bus.ce_core) step_q <= step_q + 32'd1;
      if (pressed) begin
        state    <= RESET;
        hold_cnt <= '0;
      end else if (state == RESET) begin
        state    <= MEM_UP;
        hold_cnt <= '0;
      end else if (state == MEM_UP) begin
        if (hold_cnt == 8'(RST_HOLD - 1)) state <= RUN;
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_phase_reset_ctrl.sv
// tb_phase_reset_ctrl: table, directed and random checks of two phase_reset_ctrl configurations
module tb_phase_reset_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic pr0 = 1'b1;
  logic pr1 = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  phase_reset_if if0 ();
  phase_reset_if if1 ();
  assign if0.btn_in = ~pr0;
  assign if0.phase_hold = hold;
  assign if1.btn_in = pr1;
  assign if1.phase_hold = hold;
  phase_reset_ctrl #(.NPHASE(3), .IMEM_PHASE(1), .DMEM_PHASE(2), .DEBOUNCE_LEN(16), .RST_HOLD(4), .BTN_ACT_LOW(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  phase_reset_ctrl #(.NPHASE(1), .IMEM_PHASE(0), .DMEM_PHASE(0), .DEBOUNCE_LEN(2), .RST_HOLD(8), .BTN_ACT_LOW(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  localparam int NP[2] = '{3, 1};
  localparam int IP[2] = '{1, 0};
  localparam int DP[2] = '{2, 0};
  localparam int DL[2] = '{16, 2};
  localparam int RH[2] = '{4, 8};
  // Reference: phase as a modular count, button as a window over the sample history,
  // reset stage as a function of how long the debounced button has been released.
  int          ph_m[2];
  int          rel_m[2];
  int          stage_m[2];
  bit          b_m[2];
  bit          rm_m[2];
  bit          rc_m[2];
  logic [31:0] sc_m[2];
  bit          hist[2][34];
  typedef struct {bit hold; int ph; bit cc; bit ci; bit cd;} vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(input int i, input bit p);
    bit ce, all1, all0;
    if (rst) begin
      ph_m[i] = 0; rel_m[i] = 0; stage_m[i] = 0; b_m[i] = 1; rm_m[i] = 1; rc_m[i] = 1; sc_m[i] = 0;
      for (int k = 0; k < 34; k++) hist[i][k] = 1;
    end else begin
      ce = !hold && ph_m[i] == 0;
      if (stage_m[i] == 2 && ce) sc_m[i] = sc_m[i] + 32'd1;
      rm_m[i] = stage_m[i] == 0;
      rc_m[i] = stage_m[i] != 2;
      stage_m[i] = rel_m[i] == 0 ? 0 : rel_m[i] <= RH[i] ? 1 : 2;
      for (int k = 33; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = p;
      all1 = 1; all0 = 1;
      for (int k = 2; k < DL[i] + 2; k++) begin
        all1 &= hist[i][k];
        all0 &= !hist[i][k];
      end
      if (all1) b_m[i] = 1;
      else if (all0) b_m[i] = 0;
      rel_m[i] = b_m[i] ? 0 : (rel_m[i] < 1000 ? rel_m[i] + 1 : rel_m[i]);
      if (!hold) ph_m[i] = (ph_m[i] + 1) % NP[i];
    end
  endtask
  task automatic cmp(input int i, input logic cc, input logic ci, input logic cd, input logic [2:0] phv,
                     input logic bp, input logic rmv, input logic rcv, input logic [31:0] sv);
    bit en;
    en = !rst && !hold;
    chk($sformatf("ce_core[%0d]", i), 32'(cc), 32'(en && ph_m[i] == 0));
    chk($sformatf("ce_imem[%0d]", i), 32'(ci), 32'(en && ph_m[i] == IP[i]));
    chk($sformatf("ce_dmem[%0d]", i), 32'(cd), 32'(en && ph_m[i] == DP[i]));
    chk($sformatf("phase[%0d]", i), 32'(phv), 32'(ph_m[i]));
    chk($sformatf("btn_pressed[%0d]", i), 32'(bp), 32'(b_m[i]));
    chk($sformatf("rst_mem[%0d]", i), 32'(rmv), 32'(rm_m[i]));
    chk($sformatf("rst_core[%0d]", i), 32'(rcv), 32'(rc_m[i]));
    chk($sformatf("step_cnt[%0d]", i), sv, sc_m[i]);
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step(0, pr0);
    model_step(1, pr1);
    #1;
    cmp(0, if0.ce_core, if0.ce_imem, if0.ce_dmem, if0.phase, if0.btn_pressed, if0.rst_mem, if0.rst_core, if0.step_cnt);
    cmp(1, if1.ce_core, if1.ce_imem, if1.ce_dmem, if1.phase, if1.btn_pressed, if1.rst_mem, if1.rst_core, if1.step_cnt);
  endtask
  initial begin
    int fb0, fm0, fc0, fb1, fm1, fc1, n;
    bit saw_low, back;
    logic [31:0] es;
    tbl[0]  = '{0, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0};
    tbl[2]  = '{0, 2, 0, 0, 1};
    tbl[3]  = '{0, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0};
    tbl[10] = '{0, 2, 0, 0, 1};
    tbl[11] = '{0, 0, 1, 0, 0};
    repeat (2) cyc();
    rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      hold = tbl[e].hold;
      #1;
      chk($sformatf("tbl%0d phase", e), 32'(if0.phase), 32'(tbl[e].ph));
      chk($sformatf("tbl%0d ce_core", e), 32'(if0.ce_core), 32'(tbl[e].cc));
      chk($sformatf("tbl%0d ce_imem", e), 32'(if0.ce_imem), 32'(tbl[e].ci));
      chk($sformatf("tbl%0d ce_dmem", e), 32'(if0.ce_dmem), 32'(tbl[e].cd));
      cyc();
    end
    hold = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pr0 = 1'b0;
    pr1 = 1'b0;
    fb0 = -1; fm0 = -1; fc0 = -1; fb1 = -1; fm1 = -1; fc1 = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (fb0 < 0 && if0.btn_pressed === 1'b0) fb0 = k;
      if (fm0 < 0 && if0.rst_mem === 1'b0) fm0 = k;
      if (fc0 < 0 && if0.rst_core === 1'b0) fc0 = k;
      if (fb1 < 0 && if1.btn_pressed === 1'b0) fb1 = k;
      if (fm1 < 0 && if1.rst_mem === 1'b0) fm1 = k;
      if (fc1 < 0 && if1.rst_core === 1'b0) fc1 = k;
    end
    chk("release btn0 latency", 32'(fb0), 32'd18);
    chk("release rst_mem0", 32'(fm0), 32'd20);
    chk("release rst_core0", 32'(fc0), 32'd24);
    chk("release btn1 latency", 32'(fb1), 32'd4);
    chk("release rst_mem1", 32'(fm1), 32'd6);
    chk("release rst_core1", 32'(fc1), 32'd14);
    for (int k = 0; k < 60; k++) begin
      if (k % 5 == 0) pr0 = ~pr0;
      cyc();
      chk("bounce btn0 steady", 32'(if0.btn_pressed), 32'd0);
    end
    repeat (20) cyc();
    pr1 = 1'b1;
    n = 0;
    while (if1.rst_core !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("press reaches reset1", 32'(if1.rst_core), 32'd1);
    es = sc_m[1];
    repeat (4) cyc();
    pr1 = 1'b0;
    cyc();
    cyc();
    pr1 = 1'b1;
    saw_low = 0;
    back = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (if1.rst_mem === 1'b0) saw_low = 1;
      if (saw_low && if1.rst_mem === 1'b1) back = 1;
      chk("memup abort rst_core1", 32'(if1.rst_core), 32'd1);
    end
    chk("memup abort rst_mem1 back", 32'(back), 32'd1);
    chk("step held on button reset", if1.step_cnt, es);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pr1 = 1'b0;
    for (int k = 1; k <= 113; k++) begin
      cyc();
      chk("nphase1 all ce", {29'd0, if1.ce_core, if1.ce_imem, if1.ce_dmem}, 32'd7);
    end
    chk("nphase1 step 100", if1.step_cnt, 32'd100);
    for (int k = 0; k < 600; k++) begin
      hold = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) pr0 = ~pr0;
      if ($urandom_range(0, 5) == 0) pr1 = ~pr1;
      rst = $urandom_range(0, 299) == 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
